// File: rtl/pe_pkt_pkg.sv
// pe_pkt_pkg -- shared definitions for the PE packet-input protocol.
// Holds the packet type codes, the field layout of a 32-bit NoC packet,
// the packed packet struct with its pack helper, and the enums used by
// the packet injector (cursor phase and FSM state).
package pe_pkt_pkg;

   // Packet type codes carried in bits [31:29].
   localparam logic [2:0] PKT_FILTER = 3'b000;
   localparam logic [2:0] PKT_IFMAP  = 3'b001;
   localparam logic [2:0] PKT_PSUM   = 3'b010;
   localparam logic [2:0] PKT_RESULT = 3'b011;

   // Field widths and least-significant bit positions.
   localparam int TYPE_W    = 3;
   localparam int Y_W       = 5;
   localparam int X_W       = 3;
   localparam int IDX_W     = 8;
   localparam int DATA_W    = 13;
   localparam int TYPE_LSB  = 29;
   localparam int DST_Y_LSB = 24;
   localparam int DST_X_LSB = 21;
   localparam int IDX_LSB   = 13;
   localparam int DATA_LSB  = 0;

   typedef struct packed {
      logic [TYPE_W-1:0] pkt_type;
      logic [Y_W-1:0]    dst_y;
      logic [X_W-1:0]    dst_x;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } pe_pkt_t;

   // Which stream the cursor is walking for the current PE.
   typedef enum logic [1:0] {
      PH_FILT = 2'd0,
      PH_IFM  = 2'd1,
      PH_PSUM = 2'd2
   } phase_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   function automatic pe_pkt_t pack_pkt(
      input logic [TYPE_W-1:0] pkt_type,
      input logic [Y_W-1:0]    dst_y,
      input logic [X_W-1:0]    dst_x,
      input logic [IDX_W-1:0]  idx,
      input logic [DATA_W-1:0] data
   );
      pe_pkt_t p;
      p.pkt_type = pkt_type;
      p.dst_y    = dst_y;
      p.dst_x    = dst_x;
      p.idx      = idx;
      p.data     = data;
      return p;
   endfunction

endpackage

// File: rtl/pe_inj_cursor.sv
// pe_inj_cursor -- nested y / x / phase / index walker for the injector.
// Visits PEs y-outer, x-inner; per PE walks LEN_F filter indices, then
// LEN_I ifmap indices, and (with PE_INJ_PSUM_SEED_EN defined, x=0 only)
// LEN_I-LEN_F+1 psum seed indices.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   advance            step to the next packet position
//   clear              return to PE(0,0), filter index 0 (wins over advance)
//   y, x, phase, idx   current position
//   last               current position is the final packet of the pass
//   next_psum          the position after this one is a psum seed packet
//   filt_addr          x*LEN_F + idx, truncated
//   ifm_addr           (x+y)*LEN_I + idx, truncated
module pe_inj_cursor
   import pe_pkt_pkg::*;
#(
   parameter int NUM_ROWS = 5,
   parameter int NUM_COLS = 3,
   parameter int LEN_F    = 5,
   parameter int LEN_I    = 25,
   parameter int FILT_AW  = 4,
   parameter int IFM_AW   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               advance,
   input  logic               clear,
   output logic [Y_W-1:0]     y,
   output logic [X_W-1:0]     x,
   output logic [1:0]         phase,
   output logic [IDX_W-1:0]   idx,
   output logic               last,
   output logic               next_psum,
   output logic [FILT_AW-1:0] filt_addr,
   output logic [IFM_AW-1:0]  ifm_addr
);

   phase_t phase_q;
   logic   filt_end, ifm_end, psum_end, to_psum, pe_end, last_pe;

   assign phase = phase_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      filt_end = 1'b0;
      ifm_end  = 1'b0;
      psum_end = 1'b0;
      to_psum  = 1'b0;
      filt_end = (phase_q == PH_FILT) && (idx == IDX_W'(LEN_F - 1));
      ifm_end  = (phase_q == PH_IFM)  && (idx == IDX_W'(LEN_I - 1));
      psum_end = (phase_q == PH_PSUM) && (idx == IDX_W'(LEN_I - LEN_F));
`ifdef PE_INJ_PSUM_SEED_EN
      // Column-0 PEs get their psum seed right after their ifmap row.
      to_psum  = ifm_end && (x == '0);
`else
      to_psum  = 1'b0;
`endif
      pe_end   = (ifm_end && !to_psum) || psum_end;
      last_pe  = (y == Y_W'(NUM_ROWS - 1)) && (x == X_W'(NUM_COLS - 1));
   end

   assign last      = pe_end && last_pe;
   assign next_psum = to_psum || ((phase_q == PH_PSUM) && !psum_end);

   // Modular arithmetic in the port width equals truncating the full result.
   assign filt_addr = FILT_AW'(x) * FILT_AW'(LEN_F) + FILT_AW'(idx);
   assign ifm_addr  = (IFM_AW'(x) + IFM_AW'(y)) * IFM_AW'(LEN_I) + IFM_AW'(idx);

   // NOTE: non-blocking assignments so every cursor flop updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= '0;
         x       <= '0;
         idx     <= '0;
         phase_q <= PH_FILT;
      end else if (clear) begin
         y       <= '0;
         x       <= '0;
         idx     <= '0;
         phase_q <= PH_FILT;
      end else if (advance) begin
         if (filt_end) begin
            idx     <= '0;
            phase_q <= PH_IFM;
         end else if (to_psum) begin
            idx     <= '0;
            phase_q <= PH_PSUM;
         end else if (pe_end) begin
            idx     <= '0;
            phase_q <= PH_FILT;
            if (x == X_W'(NUM_COLS - 1)) begin
               x <= '0;
               y <= (y == Y_W'(NUM_ROWS - 1)) ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_packet_injector.sv
// pe_packet_injector -- streams filter and ifmap words from two on-chip
// memories into the PE array as 32-bit NoC packets, one PE at a time.
// PE(x,y) receives filter row x and ifmap row x+y, in index order.
// Optional feature macro: PE_INJ_PSUM_SEED_EN -- emit LEN_I-LEN_F+1 zero
// psum seed packets after the ifmap packets of every x=0 PE (no reads,
// one packet per cycle).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start                         begin a pass (sampled only in IDLE)
//   busy / done                   pass in progress / one-cycle end pulse
//   filt_rd_en/addr/data          filter memory read port (1-cycle latency)
//   ifm_rd_en/addr/data           ifmap memory read port (1-cycle latency)
//   pkt_valid/pkt_ready/pkt_data  packet output, valid/ready handshake
module pe_packet_injector
   import pe_pkt_pkg::*;
#(
   parameter int WIDTH_PKT  = 32,
   parameter int WIDTH_DATA = 13,
   parameter int NUM_ROWS   = 5,
   parameter int NUM_COLS   = 3,
   parameter int LEN_F      = 5,
   parameter int LEN_I      = 25,
   parameter int FILT_AW    = 4,
   parameter int IFM_AW     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  filt_rd_en,
   output logic [FILT_AW-1:0]    filt_rd_addr,
   input  logic [WIDTH_DATA-1:0] filt_rd_data,
   output logic                  ifm_rd_en,
   output logic [IFM_AW-1:0]     ifm_rd_addr,
   input  logic [WIDTH_DATA-1:0] ifm_rd_data,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic [WIDTH_PKT-1:0]  pkt_data
);

   state_t                state, state_nxt;
   logic [Y_W-1:0]        cur_y;
   logic [X_W-1:0]        cur_x;
   logic [1:0]            cur_phase;
   logic [IDX_W-1:0]      cur_idx;
   logic                  cur_last, cur_next_psum;
   logic                  handshake, clear;
   logic [WIDTH_DATA-1:0] data_q;
   logic [TYPE_W-1:0]     pkt_type;
   pe_pkt_t               pkt;

   assign handshake = (state == S_SEND) && pkt_ready;
   assign clear     = (state == S_IDLE) && start;

   pe_inj_cursor #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .LEN_F    (LEN_F),
      .LEN_I    (LEN_I),
      .FILT_AW  (FILT_AW),
      .IFM_AW   (IFM_AW)
   ) u_cursor (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (handshake),
      .clear     (clear),
      .y         (cur_y),
      .x         (cur_x),
      .phase     (cur_phase),
      .idx       (cur_idx),
      .last      (cur_last),
      .next_psum (cur_next_psum),
      .filt_addr (filt_rd_addr),
      .ifm_addr  (ifm_rd_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RD;
         S_RD:   state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_SEND;
         S_SEND: begin
            if (pkt_ready) begin
               if (cur_last)           state_nxt = S_FIN;
               else if (cur_next_psum) state_nxt = S_SEND;  // psum seeds need no read
               else                    state_nxt = S_RD;
            end
         end
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      pkt_valid  = 1'b0;
      filt_rd_en = 1'b0;
      ifm_rd_en  = 1'b0;
      case (state)
         S_RD: begin
            busy       = 1'b1;
            filt_rd_en = (cur_phase == PH_FILT);
            ifm_rd_en  = (cur_phase == PH_IFM);
         end
         S_WAIT: busy = 1'b1;
         S_SEND: begin
            busy      = 1'b1;
            pkt_valid = 1'b1;
         end
         S_FIN:  done = 1'b1;
         default: ;
      endcase
   end

   // Read data is valid during WAIT; capture it at the end of that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 data_q <= '0;
      else if (state == S_WAIT)   data_q <= (cur_phase == PH_FILT) ? filt_rd_data : ifm_rd_data;
   end

   // Header comes straight from the cursor, which only moves on a handshake,
   // so the packet holds steady under backpressure.
   always_comb begin
      case (cur_phase)
         PH_FILT: pkt_type = PKT_FILTER;
         PH_IFM:  pkt_type = PKT_IFMAP;
         default: pkt_type = PKT_PSUM;
      endcase
      pkt      = pack_pkt(pkt_type, cur_y, cur_x, cur_idx,
                          (cur_phase == PH_PSUM) ? '0 : DATA_W'(data_q));
      pkt_data = pkt_valid ? WIDTH_PKT'(pkt) : '0;
   end

endmodule

// File: tb/tb_pe_packet_injector.sv
// tb_pe_packet_injector -- self-checking bench for pe_packet_injector.
// Builds the expected packet stream from nested loops over the PE grid,
// acts as both read memories, and checks every handshake, read strobe,
// hold condition and done pulse against that stream.
module tb_pe_packet_injector;

   localparam int NR = 5;
   localparam int NC = 3;
   localparam int LF = 5;
   localparam int LI = 25;
`ifdef PE_INJ_PSUM_SEED_EN
   localparam bit PSUM      = 1'b1;
   localparam int TOTAL_LIT = 555;
   localparam int IDX_78    = 281;
`else
   localparam bit PSUM      = 1'b0;
   localparam int TOTAL_LIT = 450;
   localparam int IDX_78    = 218;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pkt_ready = 1'b0;
   logic        busy, done, filt_rd_en, ifm_rd_en, pkt_valid;
   logic [3:0]  filt_rd_addr;
   logic [7:0]  ifm_rd_addr;
   logic [12:0] filt_rd_data = '0;
   logic [12:0] ifm_rd_data = '0;
   logic [31:0] pkt_data;

   logic [12:0] filt_mem [16];
   logic [12:0] ifm_mem  [256];

   logic [31:0] exp_pkt[$];
   int          exp_addr[$];
   int          exp_kind[$];   // 0 filter, 1 ifmap, 2 psum
   logic [31:0] obs_pkt [1024];
   int          obs_addr[1024];

   int n_checks = 0;
   int n_fail   = 0;
   int hs_count = 0;
   int done_cnt = 0;

   pe_packet_injector dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .filt_rd_en   (filt_rd_en),
      .filt_rd_addr (filt_rd_addr),
      .filt_rd_data (filt_rd_data),
      .ifm_rd_en    (ifm_rd_en),
      .ifm_rd_addr  (ifm_rd_addr),
      .ifm_rd_data  (ifm_rd_data),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .pkt_data     (pkt_data)
   );

   always #5 clk = ~clk;

   // Memories: one-cycle read latency, junk when not read.
   always @(posedge clk) begin
      filt_rd_data <= filt_rd_en ? filt_mem[filt_rd_addr] : 13'h1FFF;
      ifm_rd_data  <= ifm_rd_en  ? ifm_mem[ifm_rd_addr]   : 13'h1FFF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int t, input int y, input int x, input int i, input int d);
      return (32'(t) << 29) | (32'(y) << 24) | (32'(x) << 21) | (32'(i) << 13) | 32'(d);
   endfunction

   task automatic build_model();
      for (int y = 0; y < NR; y++) begin
         for (int x = 0; x < NC; x++) begin
            for (int j = 0; j < LF; j++) begin
               int a;
               a = x * LF + j;
               exp_pkt.push_back(mk(0, y, x, j, int'(filt_mem[a])));
               exp_addr.push_back(a);
               exp_kind.push_back(0);
            end
            for (int k = 0; k < LI; k++) begin
               int a;
               a = (x + y) * LI + k;
               exp_pkt.push_back(mk(1, y, x, k, int'(ifm_mem[a])));
               exp_addr.push_back(a);
               exp_kind.push_back(1);
            end
            if (PSUM && x == 0) begin
               for (int i = 0; i <= LI - LF; i++) begin
                  exp_pkt.push_back(mk(2, y, 0, i, 0));
                  exp_addr.push_back(-1);
                  exp_kind.push_back(2);
               end
            end
         end
      end
   endtask

   // Compare process: looks at the DUT on every falling edge.
   initial begin : monitor
      logic        prev_stall;
      logic [31:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", pkt_valid, 1);
               check("hold_data", pkt_data, prev_data);
            end
            if (filt_rd_en || ifm_rd_en) begin
               check("one_strobe", filt_rd_en & ifm_rd_en, 0);
               check("rd_in_range", hs_count < exp_pkt.size(), 1);
               if (hs_count < exp_pkt.size()) begin
                  check("rd_kind", {ifm_rd_en, filt_rd_en},
                        exp_kind[hs_count] == 0 ? 2'b01 : (exp_kind[hs_count] == 1 ? 2'b10 : 2'b00));
                  obs_addr[hs_count] = filt_rd_en ? int'(filt_rd_addr) : int'(ifm_rd_addr);
                  check("rd_addr", obs_addr[hs_count], exp_addr[hs_count]);
               end
            end
            if (pkt_valid && pkt_ready) begin
               check("hs_in_range", hs_count < exp_pkt.size(), 1);
               if (hs_count < exp_pkt.size()) begin
                  check("pkt_data", pkt_data, exp_pkt[hs_count]);
                  obs_pkt[hs_count] = pkt_data;
               end
               hs_count++;
            end
            if (done) begin
               done_cnt++;
               check("done_after_all_pkts", hs_count, exp_pkt.size());
               check("busy_low_at_done", busy, 0);
            end
            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
         end
      end
   end

   task automatic start_pass();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: ready high, stray start pulses; mode 1: ready pattern with stalls.
   task automatic run_until_done(input int budget, input int mode);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
         if (mode == 0) begin
            pkt_ready = 1'b1;
            start     = !seen && (n % 97 == 5);
         end else begin
            pkt_ready = (n % 4 != 1) && (n % 7 != 3);
         end
      end
      start = 1'b0;
      check("done_seen", seen, 1);
   endtask

   task automatic post_pass_checks();
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_valid", pkt_valid, 0);
      check("done_pulses", done_cnt, 1);
      check("total_pkts", hs_count, TOTAL_LIT);
      check("obs_first", obs_pkt[0], 32'h0000000A);
      check("obs_pe12_k3", obs_pkt[IDX_78], 32'h22206005);
      check("obs_pe12_k3_addr", obs_addr[IDX_78], 78);
`ifdef PE_INJ_PSUM_SEED_EN
      for (int i = 0; i <= 20; i++)
         check("obs_psum_seed", obs_pkt[30 + i], 32'h40000000 | (32'(i) << 13));
      check("obs_pe10_j0", obs_pkt[51], 32'h002005B9);
`endif
   endtask

   initial begin : main
      logic [31:0] held;
      bit          hit;
      for (int i = 0; i < 16; i++)  filt_mem[i] = 13'(10 + i * 291);
      for (int i = 0; i < 256; i++) ifm_mem[i]  = 13'(i * 517 + 3);
      ifm_mem[78] = 13'd5;
      build_model();
      check("model_size", exp_pkt.size(), TOTAL_LIT);
      check("model_pe12_k3", exp_pkt[IDX_78], 32'h22206005);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", pkt_valid, 0);
      check("rst_rd_en", {filt_rd_en, ifm_rd_en}, 0);
      check("rst_pkt_data", pkt_data, 0);
      check("rst_addrs", {filt_rd_addr, ifm_rd_addr}, 0);
      rst_n = 1'b1;

      // Pass 1: ready held high, first-packet latency, stray start pulses
      pkt_ready = 1'b1;
      hs_count  = 0;
      done_cnt  = 0;
      start_pass();
      check("first_rd_en", filt_rd_en, 1);
      check("first_rd_addr", filt_rd_addr, 0);
      check("first_busy", busy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("first_valid", pkt_valid, 1);
      check("first_pkt", pkt_data, 32'h0000000A);
      run_until_done(5000, 0);
      post_pass_checks();

      // Pass 2: backpressure on the first packet, then a stall pattern
      pkt_ready = 1'b0;
      hs_count  = 0;
      done_cnt  = 0;
      start_pass();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("bp_valid", pkt_valid, 1);
      held = pkt_data;
      check("bp_first_pkt", held, 32'h0000000A);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", pkt_valid, 1);
         check("bp_hold_data", pkt_data, held);
         check("bp_no_rd", filt_rd_en | ifm_rd_en, 0);
      end
      run_until_done(8000, 1);
      post_pass_checks();

      // Pass 3: reset during packet 100, then restart from PE(0,0)
      pkt_ready = 1'b1;
      hs_count  = 0;
      done_cnt  = 0;
      start_pass();
      hit = 1'b0;
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(posedge clk); #1;
         if (hs_count == 100 && pkt_valid) hit = 1'b1;
      end
      check("reached_pkt100", hit, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", pkt_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rd_en", {filt_rd_en, ifm_rd_en}, 0);
      check("mid_rst_pkt_data", pkt_data, 0);
      hs_count = 0;
      done_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_pass();
      check("restart_rd_en", filt_rd_en, 1);
      check("restart_rd_addr", filt_rd_addr, 0);
      run_until_done(5000, 0);
      post_pass_checks();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_packet_injector.md
# pe_packet_injector

Clocked packet source that streams filter and ifmap words from two on-chip memories into the PE array as 32-bit NoC packets, one PE at a time. It is the transmit end of the PE packet-input protocol and sits between the filter/ifmap memories and the NoC injection port feeding the PE split units. Each PE(x,y) receives filter row x and ifmap row x+y, in index order. Completion is reported with `done`.

## Interface

**Parameters** (name, default, meaning)

- `WIDTH_PKT`, 32, packet width.
- `WIDTH_DATA`, 13, payload width.
- `NUM_ROWS`, 5, PE rows (y).
- `NUM_COLS`, 3, PE columns (x).
- `LEN_F`, 5, filter words per PE.
- `LEN_I`, 25, ifmap words per PE; must be ≤ 256.
- `FILT_AW`, 4, filter memory address width.
- `IFM_AW`, 8, ifmap memory address width.

**Ports** (name, direction, width, meaning)

- `clk`, in, 1, single clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, begin a full injection pass; sampled only in IDLE.
- `busy`, out, 1, high from the cycle after `start` is accepted until `done`.
- `done`, out, 1, one-cycle pulse at the end of a pass.
- `filt_rd_en`, out, 1, filter memory read strobe.
- `filt_rd_addr`, out, FILT_AW, filter memory read address.
- `filt_rd_data`, in, WIDTH_DATA, filter read data; valid one cycle after `filt_rd_en`.
- `ifm_rd_en`, out, 1, ifmap memory read strobe.
- `ifm_rd_addr`, out, IFM_AW, ifmap memory read address.
- `ifm_rd_data`, in, WIDTH_DATA, ifmap read data; valid one cycle after `ifm_rd_en`.
- `pkt_valid`, out, 1, `pkt_data` holds a packet.
- `pkt_ready`, in, 1, downstream accepts; transfer when `pkt_valid` && `pkt_ready` at a rising edge.
- `pkt_data`, out, WIDTH_PKT, packet.

## Operation

- **Packet format:**
  - [31:29] type: 000 filter, 001 ifmap, 010 psum.
  - [28:24] destination y.
  - [23:21] destination x.
  - [20:13] index (write address in the PE RF).
  - [12:0] data.
- **Order:**
  - PEs are visited y = 0..NUM_ROWS-1 (outer) and x = 0..NUM_COLS-1 (inner).
  - For each PE: LEN_F filter packets (j = 0..LEN_F-1), then LEN_I ifmap packets (k = 0..LEN_I-1).
- **Addresses:**
  - `filt_rd_addr` = x*LEN_F + j.
  - `ifm_rd_addr` = (x+y)*LEN_I + k.
  - Both are truncated to the port width.
- **Packet count:** NUM_ROWS*NUM_COLS*(LEN_F+LEN_I) per pass; 450 at the defaults.
- **FSM states:** IDLE, RD, WAIT, SEND, FIN.
  - IDLE: `start`=1 → RD.
  - RD: the appropriate `*_rd_en`=1 with its address → WAIT.
  - WAIT: read data is captured into the packet register at the end of the cycle → SEND.
  - SEND: `pkt_valid`=1. On handshake, advance the cursor, then go to RD if packets remain, else FIN. Without handshake, stay in SEND.
  - FIN: `done`=1 → IDLE.
- **Hold rule:** `pkt_data` is stable while `pkt_valid` && !`pkt_ready`. `pkt_valid` never drops without a handshake.
- Exactly one of `filt_rd_en`/`ifm_rd_en` is high, and only in RD.
- `start` outside IDLE is ignored; no queuing.
- **Cursor wrap:**
  - j wraps to 0 into the ifmap phase.
  - k wraps to 0 into the next PE.
  - x wraps to 0 with y+1.
  - The last y/x/k transition goes to FIN.
- Data is passed verbatim. The index field is zero-extended to 8 bits.

## Timing

- **Reset values:** all outputs 0; FSM in IDLE; cursor at 0.
- Reset asserted mid-pass immediately drops `pkt_valid`, `busy` and the read strobes. The pass is abandoned, not resumed.
- `start` sampled high in IDLE at edge N gives RD in cycle N+1 and the first `pkt_valid` in cycle N+3.
- Minimum 3 cycles per packet with `pkt_ready` held high.
- `done` is high for the single cycle after the final handshake.
- `busy` falls in the same cycle `done` rises.
- `start` held high through FIN is accepted in the cycle after `done`.

## Configuration

- **`PE_INJ_PSUM_SEED_EN` defined:** for every PE with x=0, after its ifmap packets the block emits LEN_I-LEN_F+1 psum packets. Each has type 010, index = 0..LEN_I-LEN_F, and data 0. These carry the column-0 psum seed for PE variants without internal seeding. No memory read is issued for them; the sequence is RD-free, WAIT-free SEND only, one packet per cycle. Total is 555 at the defaults.
- **Not defined:** no psum packets are emitted.

## Structure

- **Shared package `pe_pkt_pkg`:**
  - Type constants PKT_FILTER, PKT_IFMAP, PKT_PSUM, PKT_RESULT (011).
  - Field bit positions.
  - A packed `pe_pkt_t` struct (type, dst_y, dst_x, idx, data).
  - A pack function.
- **Sub-module `pe_inj_cursor`:** nested y/x/phase/index counter. It has `advance` and `clear` inputs and produces the current indices, phase, `last` and the memory addresses. The FSM stays in the top module.

## Test plan

- **First packet:** reset; filter mem[0]=10; `start`, `pkt_ready`=1 → first packet 0x0000000A appears 3 cycles after `start`, with `filt_rd_addr`=0.
- **Mid-pass ifmap packet:** ifmap mem[78]=5 → the packet for PE(x=1,y=2), k=3 has `ifm_rd_addr`=78 and equals 0x22206005.
- **Backpressure:** hold `pkt_ready`=0 for 10 cycles in SEND → `pkt_data`/`pkt_valid` stay constant and no read strobe fires. The total remains 450 packets in order.
- **Full pass:** `pkt_ready`=1 throughout → 450 handshakes, a single `done` pulse, and `busy` low afterwards. `start` pulses during the pass are ignored.
- **Reset mid-pass:** assert `rst_n`=0 during packet 100 → outputs 0 immediately. A new `start` restarts at PE(0,0), j=0.
- **With `PE_INJ_PSUM_SEED_EN`:** after PE(0,0)'s 30 data packets → 21 packets of form 0x4000_0000 | (i<<13), then PE(1,0) filter j=0. 555 packets total.
